// File: rtl/adt7420_pkg.sv
// -----------------------------------------------------------------------------
// adt7420_pkg
// Shared definitions for the ADT7420 temperature poller: FSM state encodings,
// sensor register addresses, error codes and a small elaboration-time helper.
// -----------------------------------------------------------------------------
package adt7420_pkg;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CFG_REQ   = 3'd1;
    localparam logic [2:0] ST_CFG_RUN   = 3'd2;
    localparam logic [2:0] ST_RD_REQ    = 3'd3;
    localparam logic [2:0] ST_RD_RUN    = 3'd4;
    localparam logic [2:0] ST_WAIT_POLL = 3'd5;

    // ADT7420 register map (only the registers this block touches)
    localparam logic [7:0] REG_TEMP   = 8'h00;
    localparam logic [7:0] REG_CONFIG = 8'h03;

    // o_err_code values
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_SHORT   = 2'd3;

    // Used to size the shared timer for the larger of its two load values.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adt7420_poll_timer.sv
// -----------------------------------------------------------------------------
// adt7420_poll_timer
// Loadable down-counter with a terminal-count pulse. Shared between the poll
// interval and the request-handshake timeout (the two never run together).
//
// Ports:
//   i_clk       system clock
//   reset       synchronous active-high reset, clears the count
//   i_load      load i_load_val (has priority over counting)
//   i_load_val  value to load
//   i_cnt_en    decrement enable
//   o_tc        high for the enabled cycle in which the count is 1; with a
//               load value N the pulse arrives on the N-th enabled cycle
// -----------------------------------------------------------------------------
module adt7420_poll_timer
    import adt7420_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_cnt_en,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // NOTE: clocked state uses <= so every flop samples pre-edge values; a
    // blocking = here would let later statements see the already-updated count.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_cnt_en && (r_count != '0)) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_tc = i_cnt_en && (r_count == ONE);

endmodule

// File: rtl/adt7420_temp_poller.sv
// -----------------------------------------------------------------------------
// adt7420_temp_poller
// Sequencer in front of an i2c_master: writes the ADT7420 config register once,
// then periodically reads the 16-bit temperature register and publishes each
// good reading. Flags NACK, request-handshake timeout and short reads.
//
// Ports:
//   i_clk, reset        clock, synchronous active-high reset
//   i_en                enable polling; low lets the current transfer finish
//   o_addr_w_rw         {I2C_ADDR, rw} to i2c_master
//   o_sub_addr          {8'h00, register}
//   o_sub_len           constant 0 (8-bit register address)
//   o_byte_len          bytes to transfer
//   o_data_write        byte for the config write
//   o_req_trans         transfer request
//   i_data_out          read data byte
//   i_valid_out         i_data_out valid strobe
//   i_req_data_chunk    unused (single-byte writes only)
//   i_busy, i_nack      i2c_master status
//   o_temp_raw          last good sample, {MSB, LSB}, signed 1/128 degC
//   o_temp_valid        1-cycle pulse when o_temp_raw updates
//   o_cfg_done          config write completed with ACK
//   o_err               1-cycle pulse per failed transfer
//   o_err_code          last error (see adt7420_pkg ERR_*)
// -----------------------------------------------------------------------------
module adt7420_temp_poller
    import adt7420_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h4B,
    parameter logic [7:0] CONFIG_VAL  = 8'h80,
    parameter int         POLL_CYCLES = 25_000_000,
    parameter int         REQ_TIMEOUT = 1023
) (
    input  logic        i_clk,
    input  logic        reset,
    input  logic        i_en,
    output logic [7:0]  o_addr_w_rw,
    output logic [15:0] o_sub_addr,
    output logic        o_sub_len,
    output logic [23:0] o_byte_len,
    output logic [7:0]  o_data_write,
    output logic        o_req_trans,
    input  logic [7:0]  i_data_out,
    input  logic        i_valid_out,
    input  logic        i_req_data_chunk,
    input  logic        i_busy,
    input  logic        i_nack,
    output logic [15:0] o_temp_raw,
    output logic        o_temp_valid,
    output logic        o_cfg_done,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    // Timeout load is REQ_TIMEOUT+1 so o_req_trans drops REQ_TIMEOUT+1 edges
    // after it rose. Poll load is POLL_CYCLES-1 because entering the request
    // state and raising o_req_trans take one more edge, giving exactly
    // POLL_CYCLES edges from the busy-fall edge to the next request.
    localparam int TMR_W = $clog2(max_int(POLL_CYCLES, REQ_TIMEOUT + 2) + 1);
    localparam logic [TMR_W-1:0] POLL_LOAD = TMR_W'(POLL_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LOAD   = TMR_W'(REQ_TIMEOUT + 1);

    logic [2:0]  r_state;
    logic        r_busy_q;
    logic        r_nack_seen;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_msb;
    logic [7:0]  r_lsb;
    logic [7:0]  r_addr_w_rw;
    logic [15:0] r_sub_addr;
    logic [23:0] r_byte_len;
    logic [7:0]  r_data_write;
    logic        r_req_trans;
    logic [15:0] r_temp_raw;
    logic        r_temp_valid;
    logic        r_cfg_done;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic [2:0]       w_state_next;
    logic             w_busy_fall;
    logic             w_in_req;
    logic             w_in_run;
    logic             w_rd_run;
    logic             w_cap_msb;
    logic             w_cap_lsb;
    logic [1:0]       w_cnt_next;
    logic [7:0]       w_lsb_next;
    logic             w_enter_cfg;
    logic             w_enter_rd;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_cnt_en;
    logic             w_tmr_tc;
    logic             w_unused;

    assign w_unused    = i_req_data_chunk;
    assign w_busy_fall = r_busy_q && !i_busy;
    assign w_in_req    = (r_state == ST_CFG_REQ) || (r_state == ST_RD_REQ);
    assign w_in_run    = (r_state == ST_CFG_RUN) || (r_state == ST_RD_RUN);
    assign w_rd_run    = (r_state == ST_RD_RUN);

    // Byte capture is evaluated before the busy-fall check so a final byte
    // arriving on the same edge as the fall still counts.
    assign w_cap_msb  = w_rd_run && i_valid_out && (r_byte_cnt == 2'd0);
    assign w_cap_lsb  = w_rd_run && i_valid_out && (r_byte_cnt == 2'd1);
    assign w_cnt_next = (w_rd_run && i_valid_out && (r_byte_cnt != 2'd2))
                        ? 2'(r_byte_cnt + 2'd1) : r_byte_cnt;
    assign w_lsb_next = w_cap_lsb ? i_data_out : r_lsb;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_next = r_cfg_done ? ST_RD_REQ : ST_CFG_REQ;
                end
            end
            ST_CFG_REQ, ST_RD_REQ: begin
                if (r_req_trans) begin
                    if (i_busy) begin
                        w_state_next = (r_state == ST_CFG_REQ) ? ST_CFG_RUN : ST_RD_RUN;
                    end else if (w_tmr_tc) begin
                        w_state_next = ST_WAIT_POLL;
                    end
                end
            end
            ST_CFG_RUN: begin
                if (w_busy_fall) begin
                    if (!i_en) begin
                        w_state_next = ST_IDLE;
                    end else if (r_nack_seen) begin
                        w_state_next = ST_WAIT_POLL;
                    end else begin
                        w_state_next = ST_RD_REQ;
                    end
                end
            end
            ST_RD_RUN: begin
                if (w_busy_fall) begin
                    w_state_next = i_en ? ST_WAIT_POLL : ST_IDLE;
                end
            end
            ST_WAIT_POLL: begin
                if (!i_en) begin
                    w_state_next = ST_IDLE;
                end else if (w_tmr_tc) begin
                    w_state_next = r_cfg_done ? ST_RD_REQ : ST_CFG_REQ;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request outputs are loaded on entry to a request state so they are
    // already stable for a full cycle before o_req_trans rises.
    assign w_enter_cfg = (w_state_next == ST_CFG_REQ) && (r_state != ST_CFG_REQ);
    assign w_enter_rd  = (w_state_next == ST_RD_REQ)  && (r_state != ST_RD_REQ);

    // The timer is armed with the timeout as o_req_trans rises and with the
    // poll interval on every entry into WAIT_POLL.
    assign w_tmr_load   = (w_in_req && !r_req_trans)
                       || ((w_state_next == ST_WAIT_POLL) && (r_state != ST_WAIT_POLL));
    assign w_tmr_val    = (w_in_req && !r_req_trans) ? TO_LOAD : POLL_LOAD;
    assign w_tmr_cnt_en = (r_state == ST_WAIT_POLL) || (w_in_req && r_req_trans);

    adt7420_poll_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_cnt_en   (w_tmr_cnt_en),
        .o_tc       (w_tmr_tc)
    );

    always_ff @(posedge i_clk) begin
        if (reset) begin
            // NOTE: the byte capture registers are reset along with the
            // control state so no stale sample survives a reset.
            r_state      <= ST_IDLE;
            r_busy_q     <= 1'b0;
            r_nack_seen  <= 1'b0;
            r_byte_cnt   <= 2'd0;
            r_msb        <= 8'h00;
            r_lsb        <= 8'h00;
            r_addr_w_rw  <= {I2C_ADDR, 1'b0};
            r_sub_addr   <= 16'h0000;
            r_byte_len   <= 24'd0;
            r_data_write <= 8'h00;
            r_req_trans  <= 1'b0;
            r_temp_raw   <= 16'h0000;
            r_temp_valid <= 1'b0;
            r_cfg_done   <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_state      <= w_state_next;
            r_busy_q     <= i_busy;
            r_temp_valid <= 1'b0;
            r_err        <= 1'b0;

            if (w_enter_cfg) begin
                r_addr_w_rw  <= {I2C_ADDR, 1'b0};
                r_sub_addr   <= {8'h00, REG_CONFIG};
                r_byte_len   <= 24'd1;
                r_data_write <= CONFIG_VAL;
            end
            if (w_enter_rd) begin
                r_addr_w_rw <= {I2C_ADDR, 1'b1};
                r_sub_addr  <= {8'h00, REG_TEMP};
                r_byte_len  <= 24'd2;
            end

            // Handshake: raise, then drop on the edge busy is seen (or on timeout).
            if (w_in_req) begin
                if (!r_req_trans) begin
                    r_req_trans <= 1'b1;
                end else if (i_busy) begin
                    r_req_trans <= 1'b0;
                    r_nack_seen <= 1'b0;
                    r_byte_cnt  <= 2'd0;
                end else if (w_tmr_tc) begin
                    r_req_trans <= 1'b0;
                    r_err       <= 1'b1;
                    r_err_code  <= ERR_TIMEOUT;
                end
            end

            if (w_in_run) begin
                if (i_busy && i_nack) begin
                    r_nack_seen <= 1'b1;
                end
                if (w_cap_msb) begin
                    r_msb <= i_data_out;
                end
                if (w_cap_lsb) begin
                    r_lsb <= i_data_out;
                end
                r_byte_cnt <= w_cnt_next;

                if (w_busy_fall) begin
                    if (r_nack_seen) begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_NACK;
                    end else if (r_state == ST_CFG_RUN) begin
                        r_cfg_done <= 1'b1;
                    end else if (w_cnt_next == 2'd2) begin
                        r_temp_raw   <= {r_msb, w_lsb_next};
                        r_temp_valid <= 1'b1;
                    end else begin
                        r_err      <= 1'b1;
                        r_err_code <= ERR_SHORT;
                    end
                end
            end
        end
    end

    assign o_addr_w_rw  = r_addr_w_rw;
    assign o_sub_addr   = r_sub_addr;
    assign o_sub_len    = 1'b0;
    assign o_byte_len   = r_byte_len;
    assign o_data_write = r_data_write;
    assign o_req_trans  = r_req_trans;
    assign o_temp_raw   = r_temp_raw;
    assign o_temp_valid = r_temp_valid;
    assign o_cfg_done   = r_cfg_done;
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_adt7420_temp_poller.sv
// -----------------------------------------------------------------------------
// tb_adt7420_temp_poller
// Directed bench: a small i2c_master model answers each request; expected
// samples go into a scoreboard queue and are popped when o_temp_valid fires.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_adt7420_temp_poller;

    localparam int POLL = 100;
    localparam int TMO  = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_en = 1'b0;
    logic [7:0]  i_data_out = 8'h00;
    logic        i_valid_out = 1'b0;
    logic        i_req_data_chunk = 1'b0;
    logic        i_busy = 1'b0;
    logic        i_nack = 1'b0;
    logic [7:0]  o_addr_w_rw;
    logic [15:0] o_sub_addr;
    logic        o_sub_len;
    logic [23:0] o_byte_len;
    logic [7:0]  o_data_write;
    logic        o_req_trans;
    logic [15:0] o_temp_raw;
    logic        o_temp_valid;
    logic        o_cfg_done;
    logic        o_err;
    logic [1:0]  o_err_code;

    adt7420_temp_poller #(
        .I2C_ADDR    (7'h4B),
        .CONFIG_VAL  (8'h80),
        .POLL_CYCLES (POLL),
        .REQ_TIMEOUT (TMO)
    ) dut (
        .i_clk            (clk),
        .reset            (reset),
        .i_en             (i_en),
        .o_addr_w_rw      (o_addr_w_rw),
        .o_sub_addr       (o_sub_addr),
        .o_sub_len        (o_sub_len),
        .o_byte_len       (o_byte_len),
        .o_data_write     (o_data_write),
        .o_req_trans      (o_req_trans),
        .i_data_out       (i_data_out),
        .i_valid_out      (i_valid_out),
        .i_req_data_chunk (i_req_data_chunk),
        .i_busy           (i_busy),
        .i_nack           (i_nack),
        .o_temp_raw       (o_temp_raw),
        .o_temp_valid     (o_temp_valid),
        .o_cfg_done       (o_cfg_done),
        .o_err            (o_err),
        .o_err_code       (o_err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_valid = 0;
    int          t_fall  = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every valid pulse must match the oldest pushed sample.
    always @(negedge clk) begin
        if (o_temp_valid) begin
            logic [31:0] e;
            n_valid++;
            e = (sb_q.size() != 0) ? {16'h0, sb_q.pop_front()} : 32'hDEAD_0000;
            check("sb_sample", {16'h0, o_temp_raw}, e);
        end
    end

    // Wait (bounded) for o_req_trans; c is the cycle stamp when it is seen.
    task automatic wait_req(output int c);
        int k;
        k = 0;
        while (!o_req_trans && k < 4 * POLL + TMO) begin
            tick(1);
            k++;
        end
        c = cyc;
        check("req_seen", {31'h0, o_req_trans}, 32'd1);
    endtask

    // i2c_master model for one transfer, starting with o_req_trans high.
    task automatic serve(input string tag, input logic [7:0] exp_addr,
                         input logic [15:0] exp_sub, input logic [23:0] exp_len,
                         input int nbytes, input logic [7:0] d0, input logic [7:0] d1,
                         input bit last_on_fall, input bit do_nack, input bit en_off,
                         input bit exp_valid, input logic [1:0] exp_code, input bit exp_err);
        check({tag, "_addr"}, {24'h0, o_addr_w_rw}, {24'h0, exp_addr});
        check({tag, "_sub"}, {16'h0, o_sub_addr}, {16'h0, exp_sub});
        check({tag, "_len"}, {8'h0, o_byte_len}, {8'h0, exp_len});
        check({tag, "_sublen"}, {31'h0, o_sub_len}, 32'd0);
        tick(2);
        i_busy = 1'b1;
        tick(1);
        check({tag, "_req_drop"}, {31'h0, o_req_trans}, 32'd0);
        if (en_off) i_en = 1'b0;
        if (do_nack) begin
            i_nack = 1'b1;
            tick(1);
            i_nack = 1'b0;
        end
        for (int i = 0; i < nbytes; i++) begin
            i_data_out  = (i == 0) ? d0 : d1;
            i_valid_out = 1'b1;
            if (!(last_on_fall && i == nbytes - 1)) begin
                tick(1);
                i_valid_out = 1'b0;
                tick(1);
            end
        end
        check({tag, "_addr_hold"}, {24'h0, o_addr_w_rw}, {24'h0, exp_addr});
        i_busy = 1'b0;
        t_fall = cyc;
        tick(1);
        i_valid_out = 1'b0;
        check({tag, "_valid"}, {31'h0, o_temp_valid}, {31'h0, exp_valid});
        check({tag, "_err"}, {31'h0, o_err}, {31'h0, exp_err});
        check({tag, "_code"}, {30'h0, o_err_code}, {30'h0, exp_code});
        tick(1);
        check({tag, "_pulse_end"}, {30'h0, o_temp_valid, o_err}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_req"}, {31'h0, o_req_trans}, 32'd0);
        check({tag, "_temp"}, {16'h0, o_temp_raw}, 32'd0);
        check({tag, "_pulses"}, {30'h0, o_temp_valid, o_err}, 32'd0);
        check({tag, "_cfg_done"}, {31'h0, o_cfg_done}, 32'd0);
        check({tag, "_code"}, {30'h0, o_err_code}, 32'd0);
        check({tag, "_addr"}, {24'h0, o_addr_w_rw}, 32'h96);
        check({tag, "_sub"}, {16'h0, o_sub_addr}, 32'd0);
        check({tag, "_len"}, {8'h0, o_byte_len}, 32'd0);
        check({tag, "_data"}, {24'h0, o_data_write}, 32'd0);
    endtask

    initial begin
        int c;
        int k;
        int n_req;

        // Reset values, then idle while disabled
        tick(3);
        check_reset_state("rst");
        reset = 1'b0;
        tick(5);
        check("idle_no_req", {31'h0, o_req_trans}, 32'd0);

        // Config write, all ACK
        i_en = 1'b1;
        wait_req(c);
        check("cfg_data", {24'h0, o_data_write}, 32'h80);
        serve("cfg", 8'h96, 16'h0003, 24'd1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd0, 0);
        check("cfg_done", {31'h0, o_cfg_done}, 32'd1);

        // Read 0x0C80 (+25.0 degC), issued straight after config
        sb_q.push_back(16'h0C80);
        wait_req(c);
        serve("rd1", 8'h97, 16'h0000, 24'd2, 2, 8'h0C, 8'h80, 0, 0, 0, 1, 2'd0, 0);
        check("rd1_temp", {16'h0, o_temp_raw}, 32'h0C80);
        check("rd1_nvalid", n_valid, 32'd1);

        // Read 0xF380 (-25.0 degC), LSB coincides with busy fall
        sb_q.push_back(16'hF380);
        wait_req(c);
        check("poll_interval", c - (t_fall + 1), POLL);
        serve("rd2", 8'h97, 16'h0000, 24'd2, 2, 8'hF3, 8'h80, 1, 0, 0, 1, 2'd0, 0);
        check("rd2_temp", {16'h0, o_temp_raw}, 32'hF380);
        check("rd2_nvalid", n_valid, 32'd2);

        // Short read: one byte only
        wait_req(c);
        serve("short", 8'h97, 16'h0000, 24'd2, 1, 8'h55, 8'h00, 0, 0, 0, 0, 2'd3, 1);
        check("short_temp_hold", {16'h0, o_temp_raw}, 32'hF380);
        check("short_nvalid", n_valid, 32'd2);

        // Reset in the middle of a read
        wait_req(c);
        tick(2);
        i_busy = 1'b1;
        tick(2);
        i_data_out  = 8'h12;
        i_valid_out = 1'b1;
        tick(1);
        i_valid_out = 1'b0;
        reset  = 1'b1;
        i_busy = 1'b0;
        tick(1);
        check_reset_state("midrst");
        reset = 1'b0;

        // Config NACKed, then retried after the poll interval
        wait_req(c);
        check("cfg_nack_data", {24'h0, o_data_write}, 32'h80);
        serve("cfg_nack", 8'h96, 16'h0003, 24'd1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 2'd1, 1);
        check("cfg_nack_done", {31'h0, o_cfg_done}, 32'd0);
        wait_req(c);
        check("retry_interval", c - (t_fall + 1), POLL);
        serve("cfg_retry", 8'h96, 16'h0003, 24'd1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'd1, 0);
        check("cfg_retry_done", {31'h0, o_cfg_done}, 32'd1);

        // Request timeout: busy never rises
        wait_req(c);
        k = 0;
        while (o_req_trans && k < TMO + 10) begin
            tick(1);
            k++;
        end
        check("tmo_len", cyc - c, TMO + 1);
        check("tmo_err", {31'h0, o_err}, 32'd1);
        check("tmo_code", {30'h0, o_err_code}, 32'd2);

        // Enable dropped mid-read: transfer completes, then block idles
        sb_q.push_back(16'h0190);
        wait_req(c);
        serve("en_off", 8'h97, 16'h0000, 24'd2, 2, 8'h01, 8'h90, 0, 0, 1, 1, 2'd2, 0);
        check("en_off_nvalid", n_valid, 32'd3);
        n_req = 0;
        for (int i = 0; i < 3 * POLL; i++) begin
            tick(1);
            if (o_req_trans) n_req++;
        end
        check("en_off_idle", n_req, 32'd0);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adt7420_temp_poller.md
Name: adt7420_temp_poller

Overview:
- Upstream sequencer that drives i2c_master to configure an ADT7420 and then poll its temperature register periodically.
- Issues a one-time 1-byte config write, then 2-byte reads of register 0x00 spaced by a programmable interval.
- Assembles each reading into a 16-bit sample with a valid pulse for downstream consumers.
- Detects NACK, request timeout and short-read errors.

Parameters:
I2C_ADDR, 7'h4B, 7-bit slave address of the sensor
CONFIG_VAL, 8'h80, value written to config register 0x03 (16-bit resolution)
POLL_CYCLES, 25_000_000, idle i_clk cycles between end of one read and the next request (250 ms @100 MHz)
REQ_TIMEOUT, 1023, max cycles req_trans may stay high without busy rising

Ports:
i_clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
i_en  in  1  enable polling; low = finish current transaction, then idle
o_addr_w_rw  out  8  to i2c_master i_addr_w_rw: {I2C_ADDR, rw}
o_sub_addr  out  16  to i_sub_addr: {8'h00, reg}
o_sub_len  out  1  to i_sub_len, constant 0 (8-bit sub addr)
o_byte_len  out  24  to i_byte_len
o_data_write  out  8  to i_data_write
o_req_trans  out  1  to req_trans
i_data_out  in  8  from data_out
i_valid_out  in  1  from valid_out
i_req_data_chunk  in  1  from req_data_chunk (ignored; single-byte writes only)
i_busy  in  1  from busy
i_nack  in  1  from nack
o_temp_raw  out  16  last good sample, MSB-first, signed 1/128 °C
o_temp_valid  out  1  1-cycle pulse when o_temp_raw updates
o_cfg_done  out  1  high once config write completed without error
o_err  out  1  1-cycle pulse on any error
o_err_code  out  2  0 none, 1 NACK, 2 request timeout, 3 short read; holds last error

Behaviour:
- Reset: state IDLE.
  - o_req_trans=0, o_temp_raw=0, o_temp_valid=0, o_cfg_done=0, o_err=0, o_err_code=0.
  - o_addr_w_rw={I2C_ADDR,0}, o_sub_addr=0, o_sub_len=0, o_byte_len=0, o_data_write=0.
  - All timers cleared.
  - Reset mid-transaction drops o_req_trans the same edge; the block does not wait for i_busy.
- Request handshake:
  - Set the address, sub address, byte count and data outputs, then raise o_req_trans the following cycle.
  - Hold o_req_trans high until the cycle after i_busy is sampled high, then drop it.
  - These outputs stay stable from request until i_busy falls.
  - If REQ_TIMEOUT cycles elapse with i_busy still low: drop o_req_trans, err_code=2, go to WAIT_POLL.
- States:
  - IDLE: if i_en: go to CFG_REQ when !o_cfg_done, else RD_REQ.
  - CFG_REQ: addr_w_rw={I2C_ADDR,0}, sub_addr=0x0003, byte_len=1, data_write=CONFIG_VAL; handshake, then CFG_RUN.
  - CFG_RUN: on i_busy falling edge, o_cfg_done<=1 if no NACK was seen, then RD_REQ (or IDLE if !i_en).
  - RD_REQ: addr_w_rw={I2C_ADDR,1}, sub_addr=0x0000, byte_len=2; handshake, clear byte counter, then RD_RUN.
  - RD_RUN:
    - i_valid_out with byte counter 0 captures MSB; with counter 1 captures LSB; counter saturates at 2, and extra bytes are ignored.
    - On i_busy falling with counter==2: o_temp_raw<={MSB,LSB}, 1-cycle o_temp_valid pulse, go to WAIT_POLL.
    - On i_busy falling with counter<2 and no NACK: err_code=3, o_temp_raw unchanged.
  - WAIT_POLL: count POLL_CYCLES. At terminal count go to CFG_REQ if !o_cfg_done, else RD_REQ. If i_en is low, go to IDLE immediately.
- NACK:
  - i_nack high while i_busy is high in CFG_RUN/RD_RUN latches a NACK flag.
  - At i_busy fall: err_code=1, 1-cycle o_err pulse, no o_temp_valid, go to WAIT_POLL.
  - Config is retried on the next poll until o_cfg_done=1.
- o_err pulses exactly once per failed transaction, in the same cycle err_code updates.
- Simultaneous i_valid_out and i_busy fall: capture the byte first, then evaluate the count.
- Busy edge detection uses a 1-cycle registered i_busy.
- i_en deasserted mid-transaction: the transaction completes normally, including any o_temp_valid pulse, then the FSM goes to IDLE.

Decomposition:
- Shared package adt7420_pkg holds:
  - state enum: IDLE, CFG_REQ, CFG_RUN, RD_REQ, RD_RUN, WAIT_POLL
  - REG_TEMP=8'h00, REG_CONFIG=8'h03
  - error code constants ERR_NONE/NACK/TIMEOUT/SHORT
- One natural sub-module, adt7420_poll_timer: loadable down-counter with terminal-count pulse, used for both POLL_CYCLES and REQ_TIMEOUT.

Test Plan:
- Config write: i_en=1, i2c_master model ACKs all -> addr_w_rw=0x96, sub_addr=0x0003, byte_len=1, data_write=0x80; o_cfg_done=1.
- Read: model returns 0x0C then 0x80 -> o_temp_raw=0x0C80 (25.0 °C); one o_temp_valid pulse; next req_trans exactly POLL_CYCLES cycles after i_busy fall (POLL_CYCLES=100 in sim).
- Negative value: bytes 0xF3, 0x80 -> o_temp_raw=0xF380 (-25.0 °C).
- NACK on config: i_nack during the first transaction -> o_err pulse, err_code=1, o_cfg_done=0; the next transaction after the poll interval is a config write again.
- Short read: only one i_valid_out before i_busy falls -> err_code=3, no o_temp_valid, o_temp_raw holds its previous value.
- Timeout/reset: i_busy never rises -> o_req_trans drops after REQ_TIMEOUT+1 cycles with err_code=2; reset asserted mid-RD_RUN -> all outputs at reset values the next cycle.
